// File: rtl/load_store_unit.sv
// load_store_unit: core-side initiator for the byte-addressed data memory.
// Takes one load/store at a time in RISC-V funct3 encoding, range-checks it,
// converts it to the memory's own command encoding, and breaks misaligned
// halfword/word accesses into single-byte beats that are reassembled here.
module load_store_unit #(
  parameter int BIT_WIDTH   = 32,
  parameter int MEMORY_SIZE = 100
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_is_store,
  input  logic [2:0]           req_funct3,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [2:0]           mem_funct3,
  output logic [BIT_WIDTH-1:0] mem_addr,
  output logic [BIT_WIDTH-1:0] mem_wdata,
  input  logic [BIT_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

  // Memory-side command encodings.
  localparam logic [2:0] MEM_B   = 3'b000;
  localparam logic [2:0] MEM_H   = 3'b001;
  localparam logic [2:0] MEM_W   = 3'b010;
  localparam logic [2:0] MEM_BU  = 3'b011;
  localparam logic [2:0] MEM_HU  = 3'b100;

  // Range limit widened by one bit so addr + size cannot wrap.
  localparam logic [BIT_WIDTH:0] MEM_LIMIT = (BIT_WIDTH+1)'(MEMORY_SIZE);

  state_t               state, state_next;
  logic                 is_store_q;
  logic [2:0]           funct3_q;
  logic [BIT_WIDTH-1:0] addr_q;
  logic [BIT_WIDTH-1:0] wdata_q;
  logic [1:0]           beat_q;
  logic [2:0]           nbeats_q;
  logic [BIT_WIDTH-1:0] rdata_q;
  logic                 err_q;

  // Request decode, evaluated on the raw request while IDLE.
  logic [2:0]           req_size;
  logic                 req_legal;
  logic [BIT_WIDTH:0]   req_end;
  logic                 req_misaligned;
  logic                 req_err;
  logic                 last_beat;
  logic [BIT_WIDTH-1:0] split_word;

  // Map RISC-V funct3 to the memory's encoding.
  function automatic logic [2:0] map_funct3(input logic [2:0] f3);
    case (f3)
      3'b000:  return MEM_B;
      3'b001:  return MEM_H;
      3'b010:  return MEM_W;
      3'b100:  return MEM_BU;
      3'b101:  return MEM_HU;
      default: return MEM_B;
    endcase
  endfunction

  // Final extension of a reassembled split load.
  function automatic logic [BIT_WIDTH-1:0] extend_split(input logic [2:0] f3,
                                                        input logic [BIT_WIDTH-1:0] w);
    case (f3)
      3'b001:  return {{(BIT_WIDTH-16){w[15]}}, w[15:0]};
      3'b101:  return {{(BIT_WIDTH-16){1'b0}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Decode size, legality, range and alignment of the incoming request.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned and infers a latch.
    req_size = 3'd4;
    case (req_funct3[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
    if (req_is_store)
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                  (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    req_end        = {1'b0, req_addr} + {{(BIT_WIDTH-2){1'b0}}, req_size};
    req_misaligned = ((req_size == 3'd2) && req_addr[0]) ||
                     ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
    req_err        = !req_legal || (req_end > MEM_LIMIT);
  end

  // Split-beat bookkeeping: last-beat flag and the word with this beat's byte merged in.
  always_comb begin
    last_beat  = ({1'b0, beat_q} == (nbeats_q - 3'd1));
    split_word = rdata_q;
    split_word[{beat_q, 3'b000} +: 8] = mem_rdata[7:0];
  end

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and output decode.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = 3'b000;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)             state_next = RESP;
          else if (req_misaligned) state_next = SPLIT;
          else                     state_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_read   = !is_store_q;
        mem_write  = is_store_q;
        mem_funct3 = map_funct3(funct3_q);
        mem_addr   = addr_q;
        mem_wdata  = is_store_q ? wdata_q : '0;
        state_next = RESP;
      end
      SPLIT: begin
        mem_read   = !is_store_q;
        mem_write  = is_store_q;
        mem_funct3 = is_store_q ? MEM_B : MEM_BU;
        mem_addr   = addr_q + {{(BIT_WIDTH-2){1'b0}}, beat_q};
        mem_wdata  = is_store_q ? {{(BIT_WIDTH-8){1'b0}}, wdata_q[{beat_q, 3'b000} +: 8]} : '0;
        if (last_beat) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, beat counting and load-data assembly.
  always_ff @(posedge clock) begin
    if (reset) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      beat_q     <= 2'd0;
      nbeats_q   <= 3'd0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            beat_q     <= 2'd0;
            nbeats_q   <= req_size;
            rdata_q    <= '0;
            err_q      <= req_err;
          end
        end
        ACCESS: begin
          if (!is_store_q) rdata_q <= mem_rdata;
        end
        SPLIT: begin
          beat_q <= beat_q + 2'd1;
          if (!is_store_q)
            rdata_q <= last_beat ? extend_split(funct3_q, split_word) : split_word;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 100-byte little-endian memory model.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0]  mem [0:99];
  logic        preload;
  int          vectors = 0;
  int          miscompares = 0;
  int          strobe_count = 0;

  always #5 clock = ~clock;

  load_store_unit #(.BIT_WIDTH(32), .MEMORY_SIZE(100)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory read path: combinational, extension done by the memory itself.
  logic [31:0] a1, a2, a3;
  logic [7:0]  b0, b1, b2, b3;
  always_comb begin
    a1 = mem_addr + 32'd1;
    a2 = mem_addr + 32'd2;
    a3 = mem_addr + 32'd3;
    b0 = (mem_addr < 32'd100) ? mem[mem_addr[6:0]] : 8'h00;
    b1 = (a1 < 32'd100) ? mem[a1[6:0]] : 8'h00;
    b2 = (a2 < 32'd100) ? mem[a2[6:0]] : 8'h00;
    b3 = (a3 < 32'd100) ? mem[a3[6:0]] : 8'h00;
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{b0[7]}}, b0};
      3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b010:  mem_rdata = {b3, b2, b1, b0};
      3'b011:  mem_rdata = {24'h0, b0};
      3'b100:  mem_rdata = {16'h0, b1, b0};
      default: mem_rdata = 32'h0;
    endcase
  end

  // Memory write path, preload, and strobe-cycle counter.
  always @(posedge clock) begin
    if (mem_read || mem_write) strobe_count++;
    if (preload) begin
      for (int i = 0; i < 100; i++) mem[i] <= 8'h00;
      mem[8]  <= 8'h11; mem[9]  <= 8'h22; mem[10] <= 8'h33; mem[11] <= 8'hF4;
      mem[21] <= 8'hEE; mem[22] <= 8'hEE; mem[23] <= 8'hEE; mem[24] <= 8'hEE;
      mem[99] <= 8'h80;
    end else if (mem_write) begin
      if (mem_addr < 32'd100) mem[mem_addr[6:0]] <= mem_wdata[7:0];
      if ((mem_funct3 == 3'b001 || mem_funct3 == 3'b010) && a1 < 32'd100) mem[a1[6:0]] <= mem_wdata[15:8];
      if (mem_funct3 == 3'b010 && a2 < 32'd100) mem[a2[6:0]] <= mem_wdata[23:16];
      if (mem_funct3 == 3'b010 && a3 < 32'd100) mem[a3[6:0]] <= mem_wdata[31:24];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One complete request: strobe beats, response, handshake back to IDLE.
  // beats = 0 means an error response with no memory access.
  task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input int beats,
                         input logic [2:0] exp_mf3, input logic [31:0] exp_rdata,
                         input logic exp_err);
    int s0;
    logic [31:0] exp_wd;
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    s0 = strobe_count;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < beats; i++) begin
      check({tag, " rd"},    32'(mem_read),  32'(!st));
      check({tag, " wr"},    32'(mem_write), 32'(st));
      check({tag, " mf3"},   32'(mem_funct3), 32'(exp_mf3));
      check({tag, " maddr"}, mem_addr, addr + 32'(i));
      if (st) begin
        exp_wd = (beats == 1) ? wd : {24'h0, wd[8*i +: 8]};
        check({tag, " wdata"}, mem_wdata, exp_wd);
      end
      check({tag, " busy"}, 32'({req_ready, resp_valid}), 32'd0);
      step();
    end
    check({tag, " rvalid"}, 32'(resp_valid), 32'd1);
    check({tag, " rdata"},  resp_rdata, exp_rdata);
    check({tag, " err"},    32'(resp_err), 32'(exp_err));
    check({tag, " quiet"},  32'({mem_read, mem_write}), 32'd0);
    step();
    check({tag, " idle"},    32'({req_ready, resp_valid}), 32'b10);
    check({tag, " strobes"}, 32'(strobe_count - s0), 32'(beats));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; preload = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    step(); step();
    preload = 1'b0;
    reset   = 1'b0;
    step();

    // Reset state.
    check("rst ready",  32'(req_ready), 32'd1);
    check("rst resp",   32'({resp_valid, resp_err}), 32'd0);
    check("rst rdata",  resp_rdata, 32'd0);
    check("rst strobe", 32'({mem_read, mem_write, mem_funct3}), 32'd0);
    check("rst maddr",  mem_addr, 32'd0);
    check("rst mwdata", mem_wdata, 32'd0);

    // Aligned and split loads from the preloaded bytes.
    run_req("lw8",   1'b0, 3'b010,  8, 32'h0, 1, 3'b010, 32'hF4332211, 1'b0);
    run_req("lh9",   1'b0, 3'b001,  9, 32'h0, 2, 3'b011, 32'h00003322, 1'b0);
    run_req("lh10",  1'b0, 3'b001, 10, 32'h0, 1, 3'b001, 32'hFFFFF433, 1'b0);

    // Split store and readbacks.
    run_req("sw5",   1'b1, 3'b010,  5, 32'hA1B2C3D4, 4, 3'b000, 32'h0, 1'b0);
    run_req("lw4",   1'b0, 3'b010,  4, 32'h0, 1, 3'b010, 32'hB2C3D400, 1'b0);
    run_req("lw5",   1'b0, 3'b010,  5, 32'h0, 4, 3'b011, 32'hA1B2C3D4, 1'b0);
    run_req("lh7",   1'b0, 3'b001,  7, 32'h0, 2, 3'b011, 32'hFFFFA1B2, 1'b0);
    run_req("lhu7",  1'b0, 3'b101,  7, 32'h0, 2, 3'b011, 32'h0000A1B2, 1'b0);

    // Errors and range boundary.
    run_req("lw98",  1'b0, 3'b010, 98, 32'h0, 0, 3'b000, 32'h0, 1'b1);
    run_req("ld011", 1'b0, 3'b011,  0, 32'h0, 0, 3'b000, 32'h0, 1'b1);
    run_req("st100", 1'b1, 3'b100,  0, 32'h0, 0, 3'b000, 32'h0, 1'b1);
    run_req("lh99",  1'b0, 3'b001, 99, 32'h0, 0, 3'b000, 32'h0, 1'b1);
    run_req("lb99",  1'b0, 3'b000, 99, 32'h0, 1, 3'b000, 32'hFFFFFF80, 1'b0);

    // Aligned byte/half stores and readbacks.
    run_req("sb40",  1'b1, 3'b000, 40, 32'h12345678, 1, 3'b000, 32'h0, 1'b0);
    run_req("lbu40", 1'b0, 3'b100, 40, 32'h0, 1, 3'b011, 32'h00000078, 1'b0);
    run_req("sh30",  1'b1, 3'b001, 30, 32'h0000BEEF, 1, 3'b001, 32'h0, 1'b0);
    run_req("lh30",  1'b0, 3'b001, 30, 32'h0, 1, 3'b001, 32'hFFFFBEEF, 1'b0);

    // LBU with the response stalled for five cycles.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b100; req_addr = 32'd11; req_wdata = '0;
    step();
    req_valid = 1'b0;
    check("stall rd",   32'({mem_read, mem_funct3}), 32'b1011);
    check("stall addr", mem_addr, 32'd11);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall rvalid", 32'(resp_valid), 32'd1);
      check("stall rdata",  resp_rdata, 32'h000000F4);
      check("stall ready",  32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    step();
    check("stall done", 32'({req_ready, resp_valid}), 32'b10);

    // Reset lands on the edge that would start beat 2 of a split store.
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'd21; req_wdata = 32'h44332211;
    step();
    req_valid = 1'b0;
    check("abort b0", {mem_write, 7'h0, mem_addr[7:0], mem_wdata[15:0]}, {1'b1, 7'h0, 8'd21, 16'h0011});
    step();
    check("abort b1", {mem_write, 7'h0, mem_addr[7:0], mem_wdata[15:0]}, {1'b1, 7'h0, 8'd22, 16'h0022});
    reset = 1'b1;
    step();
    check("abort strobe", 32'({mem_read, mem_write}), 32'd0);
    check("abort state",  32'({req_ready, resp_valid}), 32'b10);
    reset = 1'b0;
    step();
    check("abort quiet", 32'({resp_valid, mem_read, mem_write}), 32'd0);
    check("abort mem",   {mem[24], mem[23], mem[22], mem[21]}, 32'hEEEE2211);
    run_req("lw21",  1'b0, 3'b010, 21, 32'h0, 4, 3'b011, 32'hEEEE2211, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the byte-addressed data memory port. It accepts one load/store request at a time from the execute stage using standard RISC-V funct3 codes and translates it to the data memory's command encoding. Misaligned halfword/word accesses, which the memory does not serve, are split into sequential unsigned-byte accesses and reassembled with sign/zero extension. It returns one response per request to writeback, and range-checks addresses before touching memory.

## Interface
- BIT_WIDTH, 32: datapath and address width; must be 32.
- MEMORY_SIZE, 100: number of bytes in the attached data memory.

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  BIT_WIDTH  byte address.
- req_wdata  in  BIT_WIDTH  store data; low bytes used per size.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  BIT_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  illegal funct3 or out-of-range access; no memory access was issued.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_funct3  out  3  memory encoding: 000 SB/LB, 001 H, 010 W, 011 LBU, 100 LHU.
- mem_addr  out  BIT_WIDTH  memory byte address.
- mem_wdata  out  BIT_WIDTH  memory write data, LSB-aligned.
- mem_rdata  in  BIT_WIDTH  memory read data, combinational from mem_addr / mem_funct3 in the same cycle.

## Operation
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE: req_ready=1. On req_valid, latch is_store/funct3/addr/wdata. Size = 1/2/4 bytes from funct3[1:0].
- Legal funct3: loads 000, 001, 010, 100, 101. Stores 000, 001, 010. Anything else is an error: go to RESP with resp_err=1.
- Range check: computed in 33 bits; addr + size > MEMORY_SIZE is an error: go to RESP, err=1. Errors issue no memory strobe.
- Aligned (addr mod size == 0) goes to ACCESS; misaligned goes to SPLIT with beat=0 and nbeats=size.
- ACCESS, one cycle. Assert mem_read or mem_write with mem_addr=addr.
  - funct3 map: 000→000, 001→001, 010→010, 100→011, 101→100.
  - Loads capture mem_rdata, which the memory has already extended.
  - Stores drive mem_wdata = req_wdata.
  - Next state: RESP.
- SPLIT, one byte per cycle. mem_addr = addr + beat.
  - Loads: mem_funct3=011; capture mem_rdata[7:0] into byte lane beat.
  - Stores: mem_funct3=000, mem_wdata = {24'b0, wdata byte beat}.
  - beat increments each cycle; at beat == nbeats-1, go to RESP.
- SPLIT load result: assembled lanes, sign-extended from bit 15 for funct3 001, zero-extended for 101, unmodified for 010.
- RESP: resp_valid=1 with registered rdata/err. When resp_ready, go to IDLE. Otherwise hold all response outputs stable.
- mem_read/mem_write are never asserted outside ACCESS/SPLIT, and never both at once. mem_* outputs are 0 in IDLE/RESP.

## Timing
- Reset: state=IDLE. After reset, req_ready=1; resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_funct3, mem_addr, mem_wdata are all 0.
- Reset mid-ACCESS/SPLIT/RESP: abort immediately. Strobes drop the cycle after reset is sampled, and the response is discarded. A partially split store leaves the earlier bytes written.
- Latency, request accepted at edge T:
  - aligned: ACCESS in cycle T+1, resp_valid from T+2.
  - misaligned half: SPLIT T+1..T+2, resp_valid from T+3.
  - misaligned word: SPLIT T+1..T+4, resp_valid from T+5.
  - error: resp_valid from T+1.
- At least one cycle between responses: RESP→IDLE, no same-cycle re-accept.
- Stores commit at the clock edge ending each ACCESS/SPLIT cycle.
- Load data is sampled at the end of the strobe cycle.

## Test plan
- Preload mem[8..11]=0x11,0x22,0x33,0xF4; LW addr 8 -> one mem_read cycle with mem_funct3=010; resp_rdata=0xF4332211 at T+2.
- Same preload; LH addr 9 -> two mem_read cycles at addr 9 then 10, mem_funct3=011; resp_rdata=0x00003322. LH addr 10 -> single ACCESS; resp 0xFFFFF433.
- SW addr 5, wdata 0xA1B2C3D4 -> four mem_write cycles at addr 5..8 with mem_wdata 0xD4, 0xC3, 0xB2, 0xA1; readback LW addr 4 shows bytes 5..7 correct.
- LW addr 98 (MEMORY_SIZE=100) and load funct3 011 -> resp_err=1, rdata=0 at T+1; mem_read/mem_write never assert.
- LBU addr 11 with resp_ready held low 5 cycles -> resp_valid and resp_rdata=0x000000F4 stable all 5 cycles; req_ready=0 until the cycle after the handshake.
- Assert reset during beat 2 of a misaligned SW -> no strobe after reset; req_ready=1 and resp_valid=0 post-reset; mem bytes at beats 0-1 changed, beats 2-3 unchanged.
